dmem_store_buffer: RTL and testbench
====================================

DMEM_STORE_BUFFER -- requirements
Module: dmem_store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered stores; the module SHALL support only powers of two, 2..16.
REQ-002 clk  input  1  single clock for all state; every register SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 StoreValidE  input  1  execute stage presents a store this cycle.
REQ-005 AddrE  input  32  store byte address; only bits [31:2] SHALL be stored.
REQ-006 MaskE  input  4  byte enables from the store write-mask stage.
REQ-007 WriteDataE  input  32  byte-replicated store data.
REQ-008 StallStore  output  1  buffer full; upstream SHALL hold its store.
REQ-009 LoadValidE  input  1  execute stage presents a load this cycle.
REQ-010 LoadAddrE  input  32  load byte address.
REQ-011 LoadHazard  output  1  load hits a pending store word; upstream SHALL stall the load.
REQ-012 MemReq  output  1  write request to data memory.
REQ-013 MemAddr  output  30  word address of the request.
REQ-014 MemMask  output  4  byte enables of the request.
REQ-015 MemData  output  32  write data of the request.
REQ-016 MemAck  input  1  memory accepts the current request at this edge.
REQ-017 Empty  output  1  no pending or in-flight store.

Function
REQ-018 Storage: circular FIFO of DEPTH entries {addr[31:2], mask, data}; read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-019 Push: when StoreValidE=1, MaskE!=0 and count<DEPTH, the entry SHALL be written at the next edge.
REQ-020 StoreValidE with MaskE=0000 SHALL be dropped silently with no push and no stall.
REQ-021 StallStore SHALL be combinational: 1 iff count==DEPTH, regardless of any same-cycle pop; a store presented while full SHALL NOT be written.
REQ-022 Drain FSM states: IDLE (MemReq=0) and REQ (MemReq=1).
REQ-023 IDLE->REQ: when count>0, the FSM SHALL load the head entry into MemAddr/MemMask/MemData and set MemReq at the next edge.
REQ-024 In REQ with MemAck=0: MemReq, MemAddr, MemMask and MemData SHALL hold stable.
REQ-025 In REQ with MemAck=1: the head SHALL be popped; if count>1 after the pop, the next entry SHALL be loaded and the FSM SHALL stay in REQ (back-to-back, one store per cycle); otherwise the FSM SHALL go to IDLE with MemReq=0.
REQ-026 The in-flight entry SHALL remain counted until it is acked.
REQ-027 MemAck while in IDLE SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; the pushed entry SHALL follow FIFO order.
REQ-029 Latency: a store accepted at edge t SHALL raise MemReq no earlier than edge t+1 when the buffer was empty and idle.
REQ-030 LoadHazard SHALL be combinational: LoadValidE=1 and any occupied entry with addr==LoadAddrE[31:2], byte offset and mask ignored.
REQ-031 LoadHazard SHALL NOT consider a store presented in the same cycle.
REQ-032 Empty SHALL be 1 iff count==0 and the FSM is in IDLE.

Reset
REQ-033 When rst_n=0 at an edge: count and pointers SHALL be 0, the FSM SHALL be IDLE, and MemReq/MemAddr/MemMask/MemData SHALL be 0; then StallStore=0 and Empty=1.
REQ-034 Reset mid-transaction SHALL discard all pending and in-flight stores; MemAck SHALL be ignored while rst_n=0.

Verification
REQ-035 Single SB: AddrE=0x103, MaskE=1000, WriteDataE=0xABABABAB, MemAck tied 1 -> one cycle later MemReq=1 with MemAddr=0x40, MemMask=1000, MemData=0xABABABAB; Empty=1 afterwards.
REQ-036 Fill: MemAck=0, five consecutive SW stores -> StallStore=1 after the 4th, 5th not written; release MemAck -> exactly 4 requests drain back-to-back in order.
REQ-037 Hazard: pending store to 0x200 with mask 0011, load at 0x202 -> LoadHazard=1; load at 0x204 -> 0; after ack of 0x200 -> 0.
REQ-038 Full with simultaneous ack and store -> store rejected (StallStore=1), count drops to 3, next cycle store accepted.
REQ-039 MaskE=0000 with StoreValidE=1 -> no push, Empty remains 1; reset asserted in REQ with 2 pending -> next cycle MemReq=0, Empty=1, a late MemAck causes no pop.

Source files
------------

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: DEPTH-entry store FIFO between execute and data memory,
// drained one request at a time with a two-state handshake FSM and a load-hazard lookup.
`default_nettype none

module dmem_store_buffer #(
    parameter int DEPTH = 4            // power of two, 2..16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StoreValidE,
    input  logic [31:0] AddrE,
    input  logic [3:0]  MaskE,
    input  logic [31:0] WriteDataE,
    output logic        StallStore,
    input  logic        LoadValidE,
    input  logic [31:0] LoadAddrE,
    output logic        LoadHazard,
    output logic        MemReq,
    output logic [29:0] MemAddr,
    output logic [3:0]  MemMask,
    output logic [31:0] MemData,
    input  logic        MemAck,
    output logic        Empty
);

    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];
    localparam logic [PW:0] CNT_ONE  = 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    logic [29:0]   addr_q [DEPTH];
    logic [3:0]    mask_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_next;
    logic [PW:0]   count;
    state_t        state;
    state_t        state_nx;
    logic          push;
    logic          pop;
    logic          load;
    logic [PW-1:0] load_idx;
    logic          hit;

    wire unused = &{1'b0, AddrE[1:0], LoadAddrE[1:0]};

    // Fullness ignores a same-cycle pop so the stall never depends on MemAck.
    assign StallStore = (count == FULL_CNT);
    assign push       = StoreValidE && (MaskE != 4'b0000) && !StallStore;
    assign pop        = (state == S_REQ) && MemAck;
    assign rd_next    = rd_ptr + PTR_ONE;
    assign MemReq     = (state == S_REQ);
    assign Empty      = (count == '0) && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= AddrE[31:2];
            mask_q[wr_ptr] <= MaskE;
            data_q[wr_ptr] <= WriteDataE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // The in-flight entry stays at rd_ptr until acked, so the follower sits at rd_ptr+1.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        load_idx = rd_ptr;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_nx = S_REQ;
                    load     = 1'b1;
                end
            end
            S_REQ: begin
                if (MemAck) begin
                    if (count > CNT_ONE) begin
                        load     = 1'b1;
                        load_idx = rd_next;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            MemAddr <= '0;
            MemMask <= '0;
            MemData <= '0;
        end else if (load) begin
            MemAddr <= addr_q[load_idx];
            MemMask <= mask_q[load_idx];
            MemData <= data_q[load_idx];
        end
    end

    // Slot i is occupied when its distance from the head is below count.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (({1'b0, PW'(i) - rd_ptr} < count) && (addr_q[i] == LoadAddrE[31:2]))
                hit = 1'b1;
        end
    end

    assign LoadHazard = LoadValidE && hit;

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed scenarios plus random traffic against a queue-based model.
`default_nettype none

module tb_dmem_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StoreValidE;
    logic [31:0] AddrE;
    logic [3:0]  MaskE;
    logic [31:0] WriteDataE;
    logic        StallStore;
    logic        LoadValidE;
    logic [31:0] LoadAddrE;
    logic        LoadHazard;
    logic        MemReq;
    logic [29:0] MemAddr;
    logic [3:0]  MemMask;
    logic [31:0] MemData;
    logic        MemAck;
    logic        Empty;

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .StoreValidE(StoreValidE), .AddrE(AddrE), .MaskE(MaskE), .WriteDataE(WriteDataE),
        .StallStore(StallStore),
        .LoadValidE(LoadValidE), .LoadAddrE(LoadAddrE), .LoadHazard(LoadHazard),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemMask(MemMask), .MemData(MemData),
        .MemAck(MemAck), .Empty(Empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    logic        m_req;
    logic [29:0] m_addr;
    logic [3:0]  m_mask;
    logic [31:0] m_data;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_load_head();
        m_addr = q[0].addr;
        m_mask = q[0].mask;
        m_data = q[0].data;
    endtask

    // Abstract buffer behaviour at one rising edge, using the inputs held across it.
    task automatic model_edge();
        bit     do_push;
        entry_t e;
        if (!rst_n) begin
            q.delete();
            m_req = 1'b0; m_addr = '0; m_mask = '0; m_data = '0;
            return;
        end
        do_push = StoreValidE && (MaskE != 4'b0) && (q.size() < DEPTH);
        if (m_req) begin
            if (MemAck) begin
                e = q.pop_front();
                if (q.size() > 0) model_load_head();
                else              m_req = 1'b0;
            end
        end else if (q.size() > 0) begin
            m_req = 1'b1;
            model_load_head();
        end
        if (do_push) q.push_back({AddrE[31:2], MaskE, WriteDataE});
    endtask

    task automatic compare_outputs();
        bit hz = 1'b0;
        foreach (q[i]) if (q[i].addr == LoadAddrE[31:2]) hz = 1'b1;
        chk("StallStore", 64'(StallStore), 64'(q.size() == DEPTH));
        chk("Empty",      64'(Empty),      64'(q.size() == 0 && !m_req));
        chk("LoadHazard", 64'(LoadHazard), 64'(LoadValidE && hz));
        chk("MemReq",     64'(MemReq),     64'(m_req));
        if (m_req) begin
            chk("MemAddr", 64'(MemAddr), 64'(m_addr));
            chk("MemMask", 64'(MemMask), 64'(m_mask));
            chk("MemData", 64'(MemData), 64'(m_data));
        end
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic step();
        #1;
        compare_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        StoreValidE = 1'b0; AddrE = '0; MaskE = '0; WriteDataE = '0;
        LoadValidE = 1'b0; LoadAddrE = '0; MemAck = 1'b0; rst_n = 1'b1;
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        StoreValidE = 1'b1; AddrE = a; MaskE = m; WriteDataE = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_edge();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_StallStore", 64'(StallStore), 64'd0);
        chk("rst_Empty",      64'(Empty),      64'd1);
        chk("rst_MemReq",     64'(MemReq),     64'd0);
        chk("rst_MemAddr",    64'(MemAddr),    64'd0);
        chk("rst_MemMask",    64'(MemMask),    64'd0);
        chk("rst_MemData",    64'(MemData),    64'd0);

        // Single byte store with MemAck tied high.
        MemAck = 1'b1;
        store(32'h103, 4'b1000, 32'hABABABAB);
        step();
        StoreValidE = 1'b0;
        #1 chk("sb_req_not_yet", 64'(MemReq), 64'd0);
        step();
        #1;
        chk("sb_MemReq",  64'(MemReq),  64'd1);
        chk("sb_MemAddr", 64'(MemAddr), 64'h40);
        chk("sb_MemMask", 64'(MemMask), 64'b1000);
        chk("sb_MemData", 64'(MemData), 64'hABABABAB);
        chk("sb_model_addr", 64'(m_addr), 64'h40);
        step();
        #1 chk("sb_Empty_after", 64'(Empty), 64'd1);
        step();

        // Fill with MemAck low: fifth store stalls and is dropped, then drain four in order.
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            store(32'h1000 + 32'(4 * k), 4'b1111, 32'h11110000 + 32'(k));
            if (k == 4) #1 chk("fill_stall_5th", 64'(StallStore), 64'd1);
            step();
        end
        StoreValidE = 1'b0;
        MemAck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("drain_req",  64'(MemReq),  64'd1);
            chk("drain_addr", 64'(MemAddr), 64'((32'h1000 + 32'(4 * k)) >> 2));
            chk("drain_data", 64'(MemData), 64'h11110000 + 64'(k));
            step();
        end
        #1;
        chk("drain_done_req",   64'(MemReq), 64'd0);
        chk("drain_done_empty", 64'(Empty),  64'd1);
        step();

        // Load hazard against a pending halfword store.
        idle_inputs();
        store(32'h200, 4'b0011, 32'h5A5A5A5A);
        step();
        StoreValidE = 1'b0;
        LoadValidE = 1'b1; LoadAddrE = 32'h202;
        #1 chk("hz_same_word", 64'(LoadHazard), 64'd1);
        step();
        LoadAddrE = 32'h204;
        #1 chk("hz_next_word", 64'(LoadHazard), 64'd0);
        step();
        MemAck = 1'b1; LoadAddrE = 32'h202;
        step();
        MemAck = 1'b0;
        #1 chk("hz_after_ack", 64'(LoadHazard), 64'd0);
        step();

        // Full with ack and store in the same cycle.
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            store(32'h2000 + 32'(4 * k), 4'b1111, 32'(k));
            step();
        end
        store(32'h3000, 4'b1111, 32'hCAFE0001);
        MemAck = 1'b1;
        #1 chk("full_ack_stall", 64'(StallStore), 64'd1);
        step();
        MemAck = 1'b0;
        #1 chk("full_ack_unstall", 64'(StallStore), 64'd0);
        chk("full_ack_count3", 64'(q.size()), 64'd3);
        step();
        StoreValidE = 1'b0;
        #1 chk("full_ack_refill", 64'(StallStore), 64'd1);
        MemAck = 1'b1;
        repeat (6) step();

        // Zero mask is dropped; reset in REQ discards everything.
        do_reset();
        store(32'h400, 4'b0000, 32'hFFFFFFFF);
        step();
        StoreValidE = 1'b0;
        #1 chk("mask0_empty", 64'(Empty), 64'd1);
        step();
        store(32'h500, 4'b1111, 32'h1); step();
        store(32'h504, 4'b1111, 32'h2); step();
        StoreValidE = 1'b0;
        #1 chk("rstreq_in_req", 64'(MemReq), 64'd1);
        rst_n = 1'b0; MemAck = 1'b1;
        step();
        rst_n = 1'b1;
        #1;
        chk("rstreq_req",   64'(MemReq), 64'd0);
        chk("rstreq_empty", 64'(Empty),  64'd1);
        step();
        MemAck = 1'b0;
        #1 chk("rstreq_late_ack", 64'(Empty), 64'd1);
        step();

        // Random traffic over a small address pool so hazards and reuse are frequent.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            StoreValidE = ($urandom_range(0, 99) < 55);
            AddrE       = 32'h300 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
            MaskE       = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            WriteDataE  = $urandom;
            LoadValidE  = $urandom_range(0, 1);
            LoadAddrE   = 32'h300 + 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
            MemAck      = ($urandom_range(0, 99) < 45);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
